// File: rtl/fb_arbiter_pkg.sv
// Shared definitions for the framebuffer arbiter: swap-state encoding and
// the log2 constant function used to size counters and pointers.
package fb_arbiter_pkg;

  typedef enum logic {
    SW_IDLE = 1'b0,
    SW_PEND = 1'b1
  } sw_state_t;

  // Ceiling log2 with a floor of 1 so single-entry pointers still get a bit.
  function automatic int log2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request after `last`,
// wrapping modulo n_writers. Purely combinational; caller owns `last`.
module rr_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int n_writers = 2,
  parameter int ptr_w     = log2(n_writers)
) (
  input  logic [n_writers-1:0] req,
  input  logic [ptr_w-1:0]     last,
  input  logic                 enable,
  output logic [n_writers-1:0] gnt,
  output logic [ptr_w-1:0]     idx
);

  logic             found;
  logic [ptr_w-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= n_writers; k++) begin
      cand = ptr_w'((int'(last) + k) % n_writers);
      if (enable && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: one grant per cycle between the display read port and
// the drawing writers, plus a front/back buffer swap aligned to refresh.
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int addr_width = 19,
  parameter int data_width = 24,
  parameter int n_writers  = 2,
  parameter int mem_lat    = 1,
  parameter int max_starve = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            refresh,
  input  logic                            disp_req,
  input  logic [addr_width-1:0]           disp_addr,
  output logic                            disp_gnt,
  output logic [data_width-1:0]           disp_rdata,
  output logic                            disp_rvalid,
  input  logic [n_writers-1:0]            wr_req,
  input  logic [n_writers*addr_width-1:0] wr_addr,
  input  logic [n_writers*data_width-1:0] wr_data,
  output logic [n_writers-1:0]            wr_gnt,
  input  logic                            swap_req,
  output logic                            swap_ack,
  output logic                            front_sel,
  output logic                            dbg_swap_state,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [addr_width:0]             mem_addr,
  output logic [data_width-1:0]           mem_wdata,
  input  logic [data_width-1:0]           mem_rdata
);

  localparam int ptr_w = log2(n_writers);
  localparam int cnt_w = log2(max_starve + 1);
  localparam logic [ptr_w-1:0] last_init = ptr_w'(n_writers - 1);

  sw_state_t        sw_state;
  logic             refresh_q;
  logic             refresh_rise;
  logic [cnt_w-1:0] starve_cnt;
  logic [ptr_w-1:0] last;
  logic [ptr_w-1:0] wr_idx;
  logic             any_wr;
  logic             force_wr;
  logic             wr_enable;
  logic             wr_any_gnt;
  logic [mem_lat:0] rd_pipe;

  // Handshake: a requester holds req (and its addr/data) until the cycle its
  // gnt is high; gnt is a same-cycle combinational accept, at most one per cycle.
  assign any_wr    = |wr_req;
  assign force_wr  = any_wr && (starve_cnt == cnt_w'(max_starve));
  assign disp_gnt  = !reset && disp_req && !force_wr;
  assign wr_enable = !reset && any_wr && (!disp_req || force_wr);

  rr_arbiter #(.n_writers(n_writers), .ptr_w(ptr_w)) u_rr (
    .req    (wr_req),
    .last   (last),
    .enable (wr_enable),
    .gnt    (wr_gnt),
    .idx    (wr_idx)
  );

  assign wr_any_gnt = |wr_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      last       <= last_init;
    end else begin
      if (wr_any_gnt) last <= wr_idx;
      if (wr_any_gnt || !any_wr)
        starve_cnt <= '0;
      else if (disp_gnt && starve_cnt != cnt_w'(max_starve))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Writes target the back buffer as seen in the grant cycle, so a write
  // granted alongside a swap still lands in the pre-swap back buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= disp_gnt || wr_any_gnt;
      mem_we <= wr_any_gnt;
      if (disp_gnt) begin
        mem_addr <= {front_sel, disp_addr};
      end else if (wr_any_gnt) begin
        mem_addr  <= {~front_sel, wr_addr[wr_idx*addr_width +: addr_width]};
        mem_wdata <= wr_data[wr_idx*data_width +: data_width];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= disp_gnt;
      for (int k = mem_lat; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    end
  end

  assign disp_rvalid = rd_pipe[mem_lat];
  assign disp_rdata  = mem_rdata;

  // Only a rising edge of refresh counts, so a stretched pulse swaps once.
  assign refresh_rise = refresh && !refresh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_state  <= SW_IDLE;
      front_sel <= 1'b0;
      swap_ack  <= 1'b0;
      refresh_q <= 1'b0;
    end else begin
      refresh_q <= refresh;
      swap_ack  <= 1'b0;
      case (sw_state)
        SW_IDLE: begin
          if (swap_req && refresh_rise) begin
            front_sel <= ~front_sel;
            swap_ack  <= 1'b1;
          end else if (swap_req) begin
            sw_state <= SW_PEND;
          end
        end
        SW_PEND: begin
          if (refresh_rise) begin
            front_sel <= ~front_sel;
            swap_ack  <= 1'b1;
            sw_state  <= SW_IDLE;
          end
        end
      endcase
    end
  end

  assign dbg_swap_state = sw_state;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_fb_arbiter;

  localparam int AW = 19;
  localparam int DW = 24;
  localparam int NW = 2;
  localparam int ML = 1;
  localparam int MS = 15;

  logic              clk;
  logic              reset;
  logic              refresh;
  logic              disp_req;
  logic [AW-1:0]     disp_addr;
  logic              disp_gnt;
  logic [DW-1:0]     disp_rdata;
  logic              disp_rvalid;
  logic [NW-1:0]     wr_req;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic [NW-1:0]     wr_gnt;
  logic              swap_req;
  logic              swap_ack;
  logic              front_sel;
  logic              dbg_swap_state;
  logic              mem_en;
  logic              mem_we;
  logic [AW:0]       mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  fb_arbiter #(
    .addr_width (AW),
    .data_width (DW),
    .n_writers  (NW),
    .mem_lat    (ML),
    .max_starve (MS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .refresh        (refresh),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_gnt       (disp_gnt),
    .disp_rdata     (disp_rdata),
    .disp_rvalid    (disp_rvalid),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_gnt         (wr_gnt),
    .swap_req       (swap_req),
    .swap_ack       (swap_ack),
    .front_sel      (front_sel),
    .dbg_swap_state (dbg_swap_state),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents are a fixed hash of the full address.
  function automatic logic [DW-1:0] pix(input logic [AW:0] a);
    logic [DW-1:0] x;
    x = DW'(a);
    return (x * DW'(40503)) ^ DW'(24'h5a5a5a);
  endfunction

  typedef struct {
    int          due;
    logic [AW:0] addr;
  } rd_t;

  rd_t rdq[$];
  rd_t mq[$];

  // Behavioural model state
  bit            armed = 0;
  int            cyc = 0;
  bit            m_front, m_pend, m_ack, m_ref_prev;
  bit            m_en, m_we;
  logic [AW:0]   m_addr;
  logic [DW-1:0] m_wdata;
  int            m_starve;
  int            m_last;
  bit            g_disp;
  logic [NW-1:0] g_wr;

  always @(negedge clk) begin
    bit            exp_disp;
    logic [NW-1:0] exp_wr;
    int            w;
    bit            any_w;
    bit            force_w;
    bit            rise;
    bit            exp_rv;
    rd_t           e;

    cyc++;
    any_w    = |wr_req;
    force_w  = any_w && (m_starve == MS);
    exp_disp = 0;
    exp_wr   = '0;
    w        = -1;
    if (!reset) begin
      if (disp_req && !force_w) exp_disp = 1;
      else if (any_w) begin
        for (int k = 1; k <= NW; k++)
          if (w < 0 && wr_req[(m_last + k) % NW]) w = (m_last + k) % NW;
        exp_wr[w] = 1'b1;
      end
    end

    if (armed) begin
      chk("disp_gnt", disp_gnt, exp_disp);
      chk("wr_gnt", wr_gnt, exp_wr);
      chk("mem_en", mem_en, m_en);
      chk("mem_we", mem_we, m_we);
      if (m_en) chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("front_sel", front_sel, m_front);
      chk("swap_ack", swap_ack, m_ack);
      chk("swap_state", dbg_swap_state, m_pend);
      exp_rv = (rdq.size() > 0) && (rdq[0].due == cyc);
      chk("disp_rvalid", disp_rvalid, exp_rv);
      if (exp_rv) begin
        chk("disp_rdata", disp_rdata, pix(rdq[0].addr));
        void'(rdq.pop_front());
      end
    end

    if (reset) begin
      m_front = 0; m_pend = 0; m_ack = 0; m_ref_prev = 0;
      m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_starve = 0; m_last = NW - 1;
      rdq.delete();
      armed = 1;
    end else begin
      m_en = exp_disp || (w >= 0);
      m_we = (w >= 0);
      if (exp_disp) begin
        m_addr = {m_front, disp_addr};
        e.due  = cyc + 1 + ML;
        e.addr = m_addr;
        rdq.push_back(e);
      end
      if (w >= 0) begin
        m_addr  = {~m_front, wr_addr[w*AW +: AW]};
        m_wdata = wr_data[w*DW +: DW];
        m_last  = w;
      end
      if (w >= 0 || !any_w) m_starve = 0;
      else if (exp_disp && m_starve < MS) m_starve++;
      rise = refresh && !m_ref_prev;
      m_ref_prev = refresh;
      m_ack = 0;
      if (rise && (m_pend || swap_req)) begin
        m_front = !m_front;
        m_pend  = 0;
        m_ack   = 1;
      end else if (swap_req) begin
        m_pend = 1;
      end
    end

    // Memory model: fixed-latency read of the hashed contents.
    if (mem_en === 1'b1 && mem_we === 1'b0) begin
      e.due  = cyc + ML;
      e.addr = mem_addr;
      mq.push_back(e);
    end
    if (mq.size() > 0 && mq[0].due == cyc + 1) begin
      mem_rdata = pix(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      mem_rdata = DW'($urandom);
    end

    g_disp = exp_disp;
    g_wr   = exp_wr;
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req = 0; wr_req = '0; refresh = 0; swap_req = 0;
  endtask

  initial begin
    logic [NW-1:0] seq[4];
    int            cnt;
    int            dprob;

    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    reset = 1; mem_rdata = '0;
    idle_inputs();
    disp_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;

    chk("rst_front_sel", front_sel, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid", disp_rvalid, 0);

    // Writers only: alternate starting from writer 0, into back buffer 1.
    wr_req  = 2'b11;
    wr_addr = {AW'(19'h1234), AW'(19'h0042)};
    wr_data = {DW'(24'hbbbbbb), DW'(24'haaaaaa)};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_seq", wr_gnt, seq[i]);
      step();
      chk("wr_buf_bit", mem_addr[AW], 1);
    end
    wr_req = '0;
    step(); step();

    // Display continuous with writer 0 waiting: 15 display grants first.
    disp_req = 1; disp_addr = AW'(19'h00777); wr_req = 2'b01;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (wr_gnt[0]) break;
      if (disp_gnt) cnt++;
      step();
    end
    chk("starve_disp_run", cnt, 15);
    step();
    repeat (20) step();
    idle_inputs();
    step(); step();

    // Swap request held pending until refresh; extra request ignored.
    swap_req = 1; step(); swap_req = 0;
    repeat (5) step();
    swap_req = 1; step(); swap_req = 0;
    repeat (3) step();
    refresh = 1; wr_req = 2'b01;
    #1;
    chk("refresh_cycle_wgnt", wr_gnt, 2'b01);
    step();
    refresh = 0; wr_req = '0;
    chk("swap_wr_buf_bit", mem_addr[AW], 1);
    chk("swap_front_1", front_sel, 1);
    chk("swap_ack_pulse", swap_ack, 1);
    step();
    chk("swap_ack_drop", swap_ack, 0);
    chk("swap_front_hold", front_sel, 1);

    // swap_req with refresh in idle swaps immediately.
    swap_req = 1; refresh = 1; step();
    swap_req = 0; refresh = 0;
    chk("imm_swap_front", front_sel, 0);
    chk("imm_swap_ack", swap_ack, 1);
    step();
    swap_req = 1; step(); swap_req = 0; step();
    swap_req = 1; step(); swap_req = 0; step();
    refresh = 1; step(); refresh = 0;
    chk("pend_swap_front", front_sel, 1);
    chk("pend_swap_ack", swap_ack, 1);
    repeat (4) step();
    chk("no_extra_toggle", front_sel, 1);

    // Reset one cycle after a display grant drops the read.
    disp_req = 1; disp_addr = AW'(19'h00abc);
    #1;
    chk("pre_reset_dgnt", disp_gnt, 1);
    step();
    disp_req = 0; reset = 1;
    #1;
    chk("reset_gnt_low", {disp_gnt, wr_gnt}, 0);
    step();
    chk("reset_no_rvalid", disp_rvalid, 0);
    chk("reset_front", front_sel, 0);
    chk("reset_mem_en", mem_en, 0);
    reset = 0; wr_req = 2'b11;
    #1;
    chk("post_reset_w0", wr_gnt, 2'b01);
    step(); step();
    idle_inputs();
    step();

    // Randomized traffic; requests held until the modelled grant.
    for (int c = 0; c < 4000; c++) begin
      dprob = ((c / 400) % 2 == 1) ? 10 : 6;
      reset = ($urandom_range(0, 699) == 0);
      if (!disp_req || g_disp) begin
        disp_req  = ($urandom_range(0, 9) < dprob);
        disp_addr = AW'($urandom);
      end
      for (int i = 0; i < NW; i++) begin
        if (!wr_req[i] || g_wr[i]) begin
          wr_req[i]            = 1'($urandom_range(0, 1));
          wr_addr[i*AW +: AW]  = AW'($urandom);
          wr_data[i*DW +: DW]  = DW'($urandom);
        end
      end
      if (refresh) refresh = 1'($urandom_range(0, 1));
      else         refresh = ($urandom_range(0, 29) == 0);
      swap_req = ($urandom_range(0, 14) == 0);
      step();
    end
    reset = 0;
    idle_inputs();
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
